// File: rtl/micro_cpu.sv
// Accumulator micro-CPU: one-word instructions fetched from an internal RAM,
// executed by a T1..T5 state sequence, with a program loader usable while stopped.
module micro_cpu #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    output logic                  halted,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  carry,
    output logic                  zero
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
        S_T4 = 3'd4, S_T5 = 3'd5, S_HALT = 3'd6
    } state_t;

    state_t                  state_r, state_s, done_s;
    logic [ADDR_WIDTH-1:0]   pc_r, mar_r, operand_r;
    logic [3:0]              opcode_r;
    logic [DATA_WIDTH-1:0]   a_r, b_r;
    logic                    carry_r, zero_r, out_valid_r;
    logic [OUT_WIDTH-1:0]    out_data_r;
    logic [DATA_WIDTH-1:0]   ram_r [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_s, diff_s, ram_wdata_s;
    logic [DATA_WIDTH:0]     sum_s;
    logic [ADDR_WIDTH-1:0]   ram_waddr_s;
    logic                    ram_we_s, busy_s, halted_s;

    assign rd_word_s = ram_r[mar_r];
    assign sum_s     = {1'b0, a_r} + {1'b0, b_r};
    assign diff_s    = a_r - b_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_s;
    end

    // Next-state logic; an instruction in flight always completes even if run drops.
    always_comb begin
        done_s  = run ? S_T1 : S_IDLE;
        state_s = S_IDLE;
        case (state_r)
            S_IDLE: state_s = run ? S_T1 : S_IDLE;
            S_T1:   state_s = S_T2;
            S_T2:   state_s = S_T3;
            S_T3: begin
                case (opcode_r)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_s = S_T4;
                    OP_HLT:                         state_s = S_HALT;
                    default:                        state_s = done_s;
                endcase
            end
            S_T4: begin
                if (opcode_r == OP_ADD || opcode_r == OP_SUB) state_s = S_T5;
                else                                          state_s = done_s;
            end
            S_T5:   state_s = done_s;
            S_HALT: state_s = run ? S_HALT : S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy_s   = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            S_T1, S_T2, S_T3, S_T4, S_T5: busy_s   = 1'b1;
            S_HALT:                       halted_s = 1'b1;
            default: begin
                busy_s   = 1'b0;
                halted_s = 1'b0;
            end
        endcase
    end

    // Datapath: PC, MAR, IR fields, accumulator, B, flags and OUT register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= '0;
            mar_r       <= '0;
            opcode_r    <= 4'h0;
            operand_r   <= '0;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                S_T1: mar_r <= pc_r;
                S_T2: begin
                    opcode_r  <= rd_word_s[DATA_WIDTH-1 -: 4];
                    operand_r <= rd_word_s[ADDR_WIDTH-1:0];
                    pc_r      <= pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
                S_T3: begin
                    case (opcode_r)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_r <= operand_r;
                        OP_OUT: begin
                            out_data_r  <= a_r[OUT_WIDTH-1:0];
                            out_valid_r <= 1'b1;
                        end
                        OP_JMP: pc_r <= operand_r;
                        OP_JC:  if (carry_r) pc_r <= operand_r;
                        OP_JZ:  if (zero_r)  pc_r <= operand_r;
                        OP_LDI: a_r <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, operand_r};
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (opcode_r)
                        OP_LDA:         a_r <= rd_word_s;
                        OP_ADD, OP_SUB: b_r <= rd_word_s;
                        default: ;
                    endcase
                end
                S_T5: begin
                    if (opcode_r == OP_ADD) begin
                        a_r     <= sum_s[DATA_WIDTH-1:0];
                        carry_r <= sum_s[DATA_WIDTH];
                        zero_r  <= (sum_s[DATA_WIDTH-1:0] == '0);
                    end else begin
                        a_r     <= diff_s;
                        carry_r <= (a_r >= b_r);
                        zero_r  <= (diff_s == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM write port: STA in T4, or the external loader while stopped.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = ld_addr;
        ram_wdata_s = ld_data;
        if (state_r == S_T4 && opcode_r == OP_STA) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = mar_r;
            ram_wdata_s = a_r;
        end else if ((state_r == S_IDLE || state_r == S_HALT) && ld_en) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // Program/data RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) ram_r[ram_waddr_s] <= ram_wdata_s;
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign halted    = halted_s;
    assign busy      = busy_s;
    assign pc        = pc_r;
    assign carry     = carry_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_micro_cpu.sv
// Bench for micro_cpu: directed program scenarios plus random straight-line
// programs checked against an instruction-level model.
module tb_micro_cpu;

    logic       clk = 1'b0;
    logic       rst_n, run, ld_en;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] out_data;
    logic       out_valid, halted, busy, carry, zero;
    logic [3:0] pc;

    int cmp_count = 0;
    int err_count = 0;

    logic [7:0] prog [16];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         cyc;
    bit         to;

    micro_cpu dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .out_data(out_data),
        .out_valid(out_valid), .halted(halted), .busy(busy),
        .pc(pc), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] w(input int op, input int opd);
        return {4'(op), 4'(opd)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; ld_en = 1'b0; ld_addr = 4'd0; ld_data = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_word(input int ad, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'(ad); ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) load_word(i, prog[i]);
    endtask

    task automatic run_until_halt(input int budget);
        got_q.delete();
        cyc = 0; to = 1'b0;
        @(negedge clk);
        run = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got_q.push_back(out_data);
            if (halted) break;
            if (cyc >= budget) begin to = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        cmp_count += 7;
        if (pc !== 4'd0)        begin err_count++; $display("FAIL reset_pc got %0d want 0", pc); end
        if (out_data !== 8'd0)  begin err_count++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        if (out_valid !== 1'b0) begin err_count++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (halted !== 1'b0)    begin err_count++; $display("FAIL reset_halted got %b want 0", halted); end
        if (busy !== 1'b0)      begin err_count++; $display("FAIL reset_busy got %b want 0", busy); end
        if (carry !== 1'b0)     begin err_count++; $display("FAIL reset_carry got %b want 0", carry); end
        if (zero !== 1'b0)      begin err_count++; $display("FAIL reset_zero got %b want 0", zero); end
    endtask

    task automatic test_program_42();
        do_reset(); clear_prog();
        prog[0] = w(1, 14); prog[1] = w(2, 15); prog[2] = w(5, 0); prog[3] = w(15, 0);
        prog[14] = 8'd28; prog[15] = 8'd14;
        load_prog();
        run_until_halt(100);
        cmp_count += 5;
        if (to !== 1'b0)         begin err_count++; $display("FAIL p42_timeout got %b want 0", to); end
        if (got_q.size() !== 1)  begin err_count++; $display("FAIL p42_out_count got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 8'd42) begin err_count++; $display("FAIL p42_out_data got %0d want 42", got_q[0]); end
        if (pc !== 4'd4)         begin err_count++; $display("FAIL p42_pc got %0d want 4", pc); end
        if (cyc !== 16)          begin err_count++; $display("FAIL p42_cycles got %0d want 16", cyc); end
    endtask

    task automatic test_add_jc();
        do_reset(); clear_prog();
        prog[0] = w(1, 13); prog[1] = w(2, 14); prog[2] = w(8, 9); prog[3] = w(15, 0);
        prog[9] = w(5, 0); prog[10] = w(15, 0); prog[13] = 8'd200; prog[14] = 8'd100;
        load_prog();
        run_until_halt(100);
        cmp_count += 4;
        if (got_q.size() !== 1)  begin err_count++; $display("FAIL jc_out_count got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 8'd44) begin err_count++; $display("FAIL jc_out_data got %0d want 44", got_q[0]); end
        if (carry !== 1'b1)      begin err_count++; $display("FAIL jc_carry got %b want 1", carry); end
        if (zero !== 1'b0)       begin err_count++; $display("FAIL jc_zero got %b want 0", zero); end
        if (pc !== 4'd11)        begin err_count++; $display("FAIL jc_pc got %0d want 11", pc); end
    endtask

    task automatic test_sub_jz();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] av, ev;
            logic [3:0] ep;
            logic       ec, ez;
            av = (k == 0) ? 8'd5 : 8'd4;
            ev = (k == 0) ? 8'h00 : 8'hFF;
            ep = (k == 0) ? 4'd14 : 4'd5;
            ec = (k == 0); ez = (k == 0);
            do_reset(); clear_prog();
            prog[0] = w(1, 10); prog[1] = w(3, 11); prog[2] = w(9, 12); prog[3] = w(5, 0);
            prog[4] = w(15, 0); prog[10] = av; prog[11] = 8'd5; prog[12] = w(5, 0); prog[13] = w(15, 0);
            load_prog();
            run_until_halt(100);
            cmp_count += 4;
            if (got_q.size() !== 1) begin err_count++; $display("FAIL sub%0d_out_count got %0d want 1", k, got_q.size()); end
            else if (got_q[0] !== ev) begin err_count++; $display("FAIL sub%0d_out_data got %0h want %0h", k, got_q[0], ev); end
            if (carry !== ec) begin err_count++; $display("FAIL sub%0d_carry got %b want %b", k, carry, ec); end
            if (zero !== ez)  begin err_count++; $display("FAIL sub%0d_zero got %b want %b", k, zero, ez); end
            if (pc !== ep)    begin err_count++; $display("FAIL sub%0d_pc got %0d want %0d", k, pc, ep); end
        end
    endtask

    task automatic test_wrap_resume();
        do_reset(); clear_prog();
        prog[0] = w(6, 14); prog[14] = w(15, 0); prog[15] = w(7, 7);
        load_prog();
        run_until_halt(100);
        cmp_count += 2;
        if (halted !== 1'b1) begin err_count++; $display("FAIL wrap_halted got %b want 1", halted); end
        if (pc !== 4'd15)    begin err_count++; $display("FAIL wrap_halt_pc got %0d want 15", pc); end
        @(negedge clk); run = 1'b0;
        @(negedge clk);
        cmp_count++;
        if (halted !== 1'b0) begin err_count++; $display("FAIL wrap_idle got halted=%b want 0", halted); end
        load_word(0, w(5, 0)); load_word(1, w(15, 0));
        run_until_halt(100);
        cmp_count += 3;
        if (got_q.size() !== 1) begin err_count++; $display("FAIL wrap_out_count got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 8'd7) begin err_count++; $display("FAIL wrap_out_data got %0d want 7", got_q[0]); end
        if (pc !== 4'd2)  begin err_count++; $display("FAIL wrap_pc got %0d want 2", pc); end
        if (cyc !== 10)   begin err_count++; $display("FAIL wrap_cycles got %0d want 10", cyc); end
    endtask

    task automatic test_reset_mid();
        do_reset(); clear_prog();
        prog[0] = w(2, 15); prog[1] = w(5, 0); prog[2] = w(15, 0); prog[15] = 8'd9;
        load_prog();
        @(negedge clk); run = 1'b1;
        repeat (4) @(negedge clk);
        cmp_count += 2;
        if (busy !== 1'b1) begin err_count++; $display("FAIL mid_busy_before got %b want 1", busy); end
        if (pc !== 4'd1)   begin err_count++; $display("FAIL mid_pc_before got %0d want 1", pc); end
        #2 rst_n = 1'b0; run = 1'b0;
        #1;
        cmp_count += 5;
        if (busy !== 1'b0)      begin err_count++; $display("FAIL mid_busy got %b want 0", busy); end
        if (pc !== 4'd0)        begin err_count++; $display("FAIL mid_pc got %0d want 0", pc); end
        if (halted !== 1'b0)    begin err_count++; $display("FAIL mid_halted got %b want 0", halted); end
        if (out_valid !== 1'b0) begin err_count++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        if ({carry, zero} !== 2'b00) begin err_count++; $display("FAIL mid_flags got %b want 00", {carry, zero}); end
        @(negedge clk); rst_n = 1'b1;
        load_word(0, w(5, 0)); load_word(1, w(15, 0));
        run_until_halt(100);
        cmp_count += 2;
        if (got_q.size() !== 1) begin err_count++; $display("FAIL mid_out_count got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 8'd0) begin err_count++; $display("FAIL mid_a_after got %0d want 0", got_q[0]); end
        if (pc !== 4'd2) begin err_count++; $display("FAIL mid_pc_after got %0d want 2", pc); end
    endtask

    task automatic test_load_guard();
        do_reset(); clear_prog();
        prog[0] = w(1, 15); prog[1] = w(5, 0); prog[2] = w(15, 0); prog[15] = 8'd11;
        load_prog();
        @(negedge clk); run = 1'b1;
        repeat (2) @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'd15; ld_data = 8'd99;
        cmp_count++;
        if (busy !== 1'b1) begin err_count++; $display("FAIL guard_busy got %b want 1", busy); end
        @(negedge clk); ld_en = 1'b0;
        run_until_halt(100);
        cmp_count++;
        if (got_q.size() !== 1) begin err_count++; $display("FAIL guard_out_count got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 8'd11) begin err_count++; $display("FAIL guard_busy_write got %0d want 11", got_q[0]); end
        load_word(3, w(7, 6)); load_word(4, w(5, 0)); load_word(5, w(15, 0));
        @(negedge clk); run = 1'b0;
        @(negedge clk);
        run_until_halt(100);
        cmp_count += 2;
        if (got_q.size() !== 1) begin err_count++; $display("FAIL guard_halt_count got %0d want 1", got_q.size()); end
        else if (got_q[0] !== 8'd6) begin err_count++; $display("FAIL guard_halt_write got %0d want 6", got_q[0]); end
        if (pc !== 4'd6) begin err_count++; $display("FAIL guard_pc got %0d want 6", pc); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [7:0] mm [16];
            int a, c, z, p, cy;
            bit done;
            for (int i = 0; i < 10; i++) begin
                int op, od;
                op = int'($urandom_range(0, 14));
                if (op >= 1 && op <= 4) od = int'($urandom_range(11, 15));
                else if (op == 6 || op == 8 || op == 9) od = int'($urandom_range(i + 1, 10));
                else od = int'($urandom_range(0, 15));
                prog[i] = w(op, od);
            end
            prog[10] = w(15, 0);
            for (int i = 11; i < 16; i++) prog[i] = 8'($urandom);
            // Instruction-level model of the program.
            for (int i = 0; i < 16; i++) mm[i] = prog[i];
            exp_q.delete();
            a = 0; c = 0; z = 0; p = 0; cy = 1; done = 1'b0;
            for (int s = 0; s < 64 && !done; s++) begin
                int wd, op, od, m;
                wd = int'(mm[p]); op = wd / 16; od = wd % 16; p = (p + 1) % 16;
                m = int'(mm[od]);
                case (op)
                    1: begin a = m; cy += 4; end
                    2: begin a = a + m; c = (a > 255) ? 1 : 0; a = a % 256; z = (a == 0) ? 1 : 0; cy += 5; end
                    3: begin c = (a >= m) ? 1 : 0; a = (a - m + 256) % 256; z = (a == 0) ? 1 : 0; cy += 5; end
                    4: begin mm[od] = 8'(a); cy += 4; end
                    5: begin exp_q.push_back(8'(a)); cy += 3; end
                    6: begin p = od; cy += 3; end
                    7: begin a = od; cy += 3; end
                    8: begin if (c != 0) p = od; cy += 3; end
                    9: begin if (z != 0) p = od; cy += 3; end
                    15: begin cy += 3; done = 1'b1; end
                    default: cy += 3;
                endcase
            end
            do_reset();
            load_prog();
            run_until_halt(400);
            cmp_count += 5;
            if (to !== 1'b0) begin err_count++; $display("FAIL rnd%0d_timeout got %b want 0", it, to); end
            if (got_q.size() !== exp_q.size()) begin err_count++; $display("FAIL rnd%0d_out_count got %0d want %0d", it, got_q.size(), exp_q.size()); end
            else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    cmp_count++;
                    if (got_q[j] !== exp_q[j]) begin err_count++; $display("FAIL rnd%0d_out%0d got %0d want %0d", it, j, got_q[j], exp_q[j]); end
                end
            end
            if (pc !== 4'(p)) begin err_count++; $display("FAIL rnd%0d_pc got %0d want %0d", it, pc, p); end
            if ({carry, zero} !== {c[0], z[0]}) begin err_count++; $display("FAIL rnd%0d_flags got %b want %b", it, {carry, zero}, {c[0], z[0]}); end
            if (cyc !== cy) begin err_count++; $display("FAIL rnd%0d_cycles got %0d want %0d", it, cyc, cy); end
        end
    endtask

    initial begin
        test_reset();
        test_program_42();
        test_add_jc();
        test_sub_jz();
        test_wrap_resume();
        test_reset_mid();
        test_load_guard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/micro_cpu.md
MICRO_CPU -- requirements
Module: micro_cpu

Interface
REQ-001 Parameter DATA_WIDTH, default 8, accumulator/RAM word width; SHALL satisfy DATA_WIDTH >= 4+ADDR_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 4, PC/operand width; RAM depth 2^ADDR_WIDTH.
REQ-003 Parameter OUT_WIDTH, default 8, output port width; SHALL satisfy OUT_WIDTH <= DATA_WIDTH.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  level; 1 permits execution.
REQ-007 ld_en  input  1  program-load write strobe.
REQ-008 ld_addr  input  ADDR_WIDTH  load address.
REQ-009 ld_data  input  DATA_WIDTH  load data.
REQ-010 out_data  output  OUT_WIDTH  registered OUT value.
REQ-011 out_valid  output  1  one-cycle pulse per OUT.
REQ-012 halted  output  1  high in HALT state.
REQ-013 busy  output  1  high in T1..T5.
REQ-014 pc  output  ADDR_WIDTH  program counter.
REQ-015 carry, zero  output  1 each  ALU flags.

Function
REQ-016 Instruction: opcode = word[DATA_WIDTH-1 -: 4], operand = word[ADDR_WIDTH-1:0]; bits between ignored.
REQ-017 Opcodes SHALL be: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 OUT, 6 JMP, 7 LDI, 8 JC, 9 JZ, F HLT; A-E execute as NOP.
REQ-018 RAM: 2^ADDR_WIDTH x DATA_WIDTH, combinational read, write on clock edge; contents not reset.
REQ-019 States: IDLE, T1 (MAR<=PC), T2 (IR<=RAM[MAR], PC<=PC+1), T3, T4, T5, HALT.
REQ-020 IDLE -> T1 when run=1; stays IDLE otherwise.
REQ-021 T3: LDA/ADD/SUB/STA MAR<=operand -> T4; OUT out_data<=A[OUT_WIDTH-1:0], out_valid=1 next cycle; JMP PC<=operand; JC PC<=operand iff carry; JZ PC<=operand iff zero; LDI A<=zero-extended operand; NOP no-op; HLT -> HALT.
REQ-022 T4: LDA A<=RAM[MAR]; STA RAM[MAR]<=A; ADD/SUB B<=RAM[MAR] -> T5.
REQ-023 T5: ADD A<=A+B, carry=carry-out of DATA_WIDTH; SUB A<=A-B, carry=1 iff A>=B (no borrow); both zero=(result==0).
REQ-024 Latency: NOP/OUT/JMP/JC/JZ/LDI 3 cycles, LDA/STA 4, ADD/SUB 5; result visible cycle after final stage.
REQ-025 Flags change only on ADD/SUB completion.
REQ-026 End of instruction -> T1 if run=1, else IDLE; run deassert mid-instruction SHALL NOT abort it.
REQ-027 HALT -> IDLE when run=0; PC retains HLT address+1; re-run resumes there.
REQ-028 PC increments modulo 2^ADDR_WIDTH (wrap to 0).
REQ-029 ld_en honoured only in IDLE or HALT (RAM[ld_addr]<=ld_data); ignored while busy.
REQ-030 out_valid low in every cycle not following an OUT T3.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, PC/A/B/IR/MAR=0, carry=zero=0, out_data=0, out_valid=0, halted=0, busy=0, including mid-instruction.
REQ-032 After rst_n rises, execution starts at address 0 on first edge with run=1.

Verification
REQ-033 Load {0:LDA 14, 1:ADD 15, 2:OUT, 3:HLT, 14:28, 15:14}, run=1 -> single out_valid pulse with out_data=42, then halted=1, pc=4.
REQ-034 A=200, ADD mem=100, then JC 9 -> A=44, carry=1, zero=0, pc=9.
REQ-035 A=5, SUB mem=5, then JZ 12 -> A=0, zero=1, carry=1, pc=12; with A=4 -> carry=0, A=0xFF, JZ not taken.
REQ-036 LDI 7 at address 15, run held -> next fetch from address 0, A=7.
REQ-037 rst_n low during ADD T4 -> all outputs at reset values same cycle, A unchanged from 0, busy=0.
REQ-038 ld_en pulse while busy -> RAM unchanged; same pulse in HALT -> word written and executed after rerun.
